// File: rtl/uart_alu_interface.sv
// Sequences three received bytes (A, B, opcode) onto the ALU buses, then hands the
// ALU result to the UART transmitter and waits for its end-of-frame pulse.
module uart_alu_interface #(
   parameter int unsigned DBIT  = 8,
   parameter int unsigned NB_OP = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_data_ready,
   input  logic [DBIT-1:0]  rx_data,
   input  logic [DBIT-1:0]  alu_result,
   input  logic             tx_done,
   output logic [DBIT-1:0]  alu_a,
   output logic [DBIT-1:0]  alu_b,
   output logic [NB_OP-1:0] alu_op,
   output logic [DBIT-1:0]  tx_data,
   output logic             tx_start,
   output logic             busy,
   output logic             rx_overrun
);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   state_t           r_state;
   logic             r_rdy_q;
   logic [DBIT-1:0]  r_alu_a;
   logic [DBIT-1:0]  r_alu_b;
   logic [NB_OP-1:0] r_alu_op;
   logic [DBIT-1:0]  r_tx_data;
   logic             r_tx_start;
   logic             r_busy;
   logic             r_rx_overrun;
   logic             w_byte_evt;

   // r_rdy_q resets high so a level already asserted at reset release is not a byte
   assign w_byte_evt = rx_data_ready & ~r_rdy_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= WAIT_A;
         r_rdy_q      <= 1'b1;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_tx_data    <= '0;
         r_tx_start   <= 1'b0;
         r_busy       <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         r_rdy_q      <= rx_data_ready;
         r_rx_overrun <= 1'b0;
         case (r_state)
            WAIT_A: begin
               if (w_byte_evt) begin
                  r_alu_a <= rx_data;
                  r_state <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (w_byte_evt) begin
                  r_alu_b <= rx_data;
                  r_state <= WAIT_OP;
               end
            end
            WAIT_OP: begin
               if (w_byte_evt) begin
                  r_alu_op <= rx_data[NB_OP-1:0];
                  r_busy   <= 1'b1;
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               r_tx_data    <= alu_result;
               r_tx_start   <= 1'b1;
               r_rx_overrun <= w_byte_evt;
               r_state      <= WAIT_TX;
            end
            WAIT_TX: begin
               r_tx_start   <= 1'b0;
               // a byte arriving alongside tx_done is still dropped
               r_rx_overrun <= w_byte_evt;
               if (tx_done) begin
                  r_busy  <= 1'b0;
                  r_state <= WAIT_A;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= WAIT_A;
            end
         endcase
      end
   end

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign tx_data    = r_tx_data;
   assign tx_start   = r_tx_start;
   assign busy       = r_busy;
   assign rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: table of full transactions plus
// hand-written sequences for level inputs, overrun, reset and a slow transmitter.
module tb_uart_alu_interface;

   localparam int DBIT  = 8;
   localparam int NB_OP = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic             rx_data_ready;
   logic [DBIT-1:0]  rx_data;
   logic [DBIT-1:0]  alu_result;
   logic             tx_done;
   logic [DBIT-1:0]  alu_a;
   logic [DBIT-1:0]  alu_b;
   logic [NB_OP-1:0] alu_op;
   logic [DBIT-1:0]  tx_data;
   logic             tx_start;
   logic             busy;
   logic             rx_overrun;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int ovr_cnt = 0;

   uart_alu_interface #(.DBIT(DBIT), .NB_OP(NB_OP)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data_ready (rx_data_ready),
      .rx_data       (rx_data),
      .alu_result    (alu_result),
      .tx_done       (tx_done),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_op        (alu_op),
      .tx_data       (tx_data),
      .tx_start      (tx_start),
      .busy          (busy),
      .rx_overrun    (rx_overrun)
   );

   always #5 clk = ~clk;

   // Simple MIPS-style function-code ALU standing in for the real one
   always_comb begin
      alu_result = '0;
      case (alu_op)
         6'h20:   alu_result = alu_a + alu_b;
         6'h22:   alu_result = alu_a - alu_b;
         6'h24:   alu_result = alu_a & alu_b;
         6'h25:   alu_result = alu_a | alu_b;
         6'h26:   alu_result = alu_a ^ alu_b;
         6'h27:   alu_result = ~(alu_a | alu_b);
         default: alu_result = '0;
      endcase
   end

   // Count high cycles of the pulse outputs
   always @(posedge clk) begin
      if (tx_start)   start_cnt++;
      if (rx_overrun) ovr_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int len);
      @(negedge clk);
      rx_data       = b;
      rx_data_ready = 1'b1;
      repeat (len) @(negedge clk);
      rx_data_ready = 1'b0;
   endtask

   // Sends A, B, OP as one-cycle pulses and checks capture and the tx_start pulse
   task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp_res);
      int s0;
      s0 = start_cnt;
      send_byte(a, 1);
      chk("alu_a", alu_a, a);
      chk("busy_in_wait_b", busy, 0);
      send_byte(b, 1);
      chk("alu_b", alu_b, b);
      send_byte(op, 1);
      chk("alu_op", alu_op, {26'd0, op[5:0]});
      chk("busy_exec", busy, 1);
      chk("tx_start_exec", tx_start, 0);
      @(negedge clk);
      chk("tx_start_e1", tx_start, 1);
      chk("tx_data", tx_data, exp_res);
      @(negedge clk);
      chk("tx_start_e2", tx_start, 0);
      chk("busy_wait_tx", busy, 1);
      chk("tx_start_count", start_cnt - s0, 1);
   endtask

   task automatic finish_tx();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("busy_after_done", busy, 0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [7:0] res;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int s0;
      int o0;
      int bad;

      vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, res: 8'h08};
      vecs[1] = '{a: 8'h10, b: 8'h04, op: 8'h22, res: 8'h0C};
      vecs[2] = '{a: 8'hF0, b: 8'h0F, op: 8'h25, res: 8'hFF};
      vecs[3] = '{a: 8'h3C, b: 8'h0F, op: 8'hE4, res: 8'h0C};
      vecs[4] = '{a: 8'h00, b: 8'h01, op: 8'h22, res: 8'hFF};

      // Reset with rx_data_ready already high: the held level must not count
      reset         = 1'b0;
      rx_data_ready = 1'b1;
      rx_data       = 8'h77;
      tx_done       = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", rx_overrun, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("level_at_release_ignored", alu_a, 0);
      rx_data_ready = 1'b0;
      @(negedge clk);
      $display("txn reset: reset values and held-level release checked");

      // Table of complete transactions, back-to-back
      for (int i = 0; i < 5; i++) begin
         do_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res);
         finish_tx();
         $display("txn %0d: A=%02h B=%02h OP=%02h -> tx_data=%02h", i, vecs[i].a,
                  vecs[i].b, vecs[i].op, tx_data);
      end

      // Held level: each byte held for 5 cycles yields exactly one capture
      s0 = start_cnt;
      o0 = ovr_cnt;
      send_byte(8'hAA, 5);
      chk("held_a", alu_a, 8'hAA);
      send_byte(8'h55, 5);
      chk("held_b", alu_b, 8'h55);
      chk("held_a_kept", alu_a, 8'hAA);
      send_byte(8'h26, 5);
      @(negedge clk);
      chk("held_op", alu_op, 6'b100110);
      chk("held_tx_data", tx_data, 8'hFF);
      chk("held_start_count", start_cnt - s0, 1);
      chk("held_no_overrun", ovr_cnt - o0, 0);
      finish_tx();
      $display("txn held-level: A=%02h B=%02h OP=%02h tx_data=%02h", alu_a, alu_b, alu_op, tx_data);

      // Overrun during WAIT_TX, then next byte after tx_done becomes A
      do_txn(8'h07, 8'h02, 8'h20, 8'h09);
      o0 = ovr_cnt;
      send_byte(8'h11, 1);
      chk("ovr_pulse", rx_overrun, 1);
      chk("ovr_alu_a_kept", alu_a, 8'h07);
      chk("ovr_busy", busy, 1);
      @(negedge clk);
      chk("ovr_pulse_end", rx_overrun, 0);
      chk("ovr_count", ovr_cnt - o0, 1);
      finish_tx();
      send_byte(8'h22, 1);
      chk("after_ovr_a", alu_a, 8'h22);
      send_byte(8'h01, 1);
      send_byte(8'h20, 1);
      @(negedge clk);
      chk("after_ovr_tx_data", tx_data, 8'h23);
      finish_tx();
      $display("txn overrun: dropped byte 11, next A=%02h tx_data=%02h", alu_a, tx_data);

      // Byte in the same cycle as tx_done is an overrun; byte one cycle later is A
      do_txn(8'h09, 8'h09, 8'h24, 8'h09);
      o0 = ovr_cnt;
      @(negedge clk);
      tx_done       = 1'b1;
      rx_data       = 8'h44;
      rx_data_ready = 1'b1;
      @(negedge clk);
      tx_done       = 1'b0;
      rx_data_ready = 1'b0;
      chk("same_cycle_ovr", rx_overrun, 1);
      chk("same_cycle_busy", busy, 0);
      chk("same_cycle_a_kept", alu_a, 8'h09);
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done       = 1'b0;
      rx_data       = 8'h33;
      rx_data_ready = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
      chk("tx_done_in_wait_b_ignored", alu_a, 8'h33);
      chk("same_cycle_ovr_count", ovr_cnt - o0, 1);
      send_byte(8'h03, 1);
      send_byte(8'h20, 1);
      @(negedge clk);
      chk("ek1_tx_data", tx_data, 8'h36);
      finish_tx();
      $display("txn tx_done boundary: A=%02h tx_data=%02h", alu_a, tx_data);

      // Reset mid-transaction
      send_byte(8'h0F, 1);
      chk("mid_a", alu_a, 8'h0F);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mid_rst_a", alu_a, 0);
      chk("mid_rst_tx_data", tx_data, 0);
      chk("mid_rst_busy", busy, 0);
      do_txn(8'h01, 8'h02, 8'h20, 8'h03);
      finish_tx();
      $display("txn reset-mid: tx_data=%02h", tx_data);

      // Slow transmitter: no tx_done for 1000 cycles
      s0  = start_cnt;
      bad = 0;
      do_txn(8'h0A, 8'h05, 8'h27, 8'hF0);
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (!busy || tx_start) bad++;
      end
      chk("slow_busy_held", bad, 0);
      chk("slow_start_once", start_cnt - s0, 1);
      chk("slow_tx_data_kept", tx_data, 8'hF0);
      send_byte(8'h99, 1);
      chk("slow_still_wait_tx", alu_a, 8'h0A);
      finish_tx();
      $display("txn slow-tx: tx_data=%02h held 1000 cycles", tx_data);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
